// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: ALU pass-through, single-port dmem req/ack access, load alignment and extension.
// Optional build macro MISALIGN_TRAP_EN adds the misalign port and traps misaligned half/word accesses.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemUnsigned,
  input  logic [DATA_W-1:0] StoreData,
  output logic              ex_ready,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          offset_q, offset_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
`ifdef MISALIGN_TRAP_EN
  logic                misalign_q, misalign_d;
`endif

  // Byte lanes touched by an access; misaligned halves fall back to their aligned pair.
  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = 4'b0011 << {off[1], 1'b0};
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] calc_wdata(input logic [1:0] size,
                                                   input logic [DATA_W-1:0] sd);
    logic [DATA_W-1:0] wd;
    wd = sd;
    case (size)
      SIZE_BYTE: wd = {4{sd[7:0]}};
      SIZE_HALF: wd = {2{sd[15:0]}};
      default:   wd = sd;
    endcase
    return wd;
  endfunction

  // Right-justify the addressed lanes of the raw word and extend to full width.
  function automatic logic [DATA_W-1:0] load_align(input logic [1:0] size,
                                                   input logic [1:0] off,
                                                   input logic uns,
                                                   input logic [DATA_W-1:0] raw);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] res;
    sh  = raw;
    res = raw;
    case (size)
      SIZE_BYTE: begin
        sh  = raw >> {off, 3'b000};
        res = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      SIZE_HALF: begin
        sh  = raw >> {off[1], 4'b0000};
        res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: res = raw;
    endcase
    return res;
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SIZE_HALF) && off[0]) || (size[1] && (off != 2'b00));
  endfunction
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    size_d     = size_q;
    uns_d      = uns_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (MemRead || MemWrite) begin
`ifdef MISALIGN_TRAP_EN
            if (is_misaligned(MemSize, ALUResult[1:0])) begin
              misalign_d = 1'b1;
            end else begin
`else
            begin
`endif
              offset_d = ALUResult[1:0];
              size_d   = MemSize;
              uns_d    = MemUnsigned;
              req_d    = 1'b1;
              we_d     = MemWrite;
              addr_d   = {ALUResult[ADDR_W-1:2], 2'b00};
              wdata_d  = calc_wdata(MemSize, StoreData);
              be_d     = calc_be(MemSize, ALUResult[1:0]);
              state_d  = WAIT;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = DATA_W'(ALUResult);
          end
        end
      end
      WAIT: begin
        // Request and payload stay frozen until the memory acknowledges.
        if (dmem_ack) begin
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = we_q ? '0 : load_align(size_q, offset_q, uns_q, dmem_rdata);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      offset_q   <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign ex_ready   = (state_q == IDLE);
  assign stall      = ~ex_ready;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign   = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand sequences for reset/pass-through, randomized ops vs a lane-level model.
module tb_mem_access_unit;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic        clk, reset, ex_valid, MemRead, MemWrite, MemUnsigned;
  logic [1:0]  MemSize;
  logic [31:0] ALUResult, StoreData;
  logic        ex_ready, stall, dmem_req, dmem_we, dmem_ack, wb_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data;
  logic [3:0]  dmem_be;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ALUResult(ALUResult),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemUnsigned(MemUnsigned),
    .StoreData(StoreData), .ex_ready(ex_ready), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data)
`ifdef MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Lane-level reference: an access covers n bytes starting at the offset rounded down to n.
  function automatic void model(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic un, input logic [31:0] alu, input logic [31:0] sd,
                                input logic [31:0] rdata,
                                output logic [31:0] addr, output logic [31:0] wdata,
                                output logic [31:0] res, output logic [3:0] be,
                                output logic we, output logic trap);
    int n, lo, off;
    logic [31:0] v;
    off  = int'(alu[1:0]);
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lo   = off - (off % n);
    trap = TRAP_ON && ((off % n) != 0);
    addr = alu & ~32'd3;
    we   = wr;
    for (int i = 0; i < 4; i++) begin
      be[i]          = (i >= lo) && (i < lo + n);
      wdata[8*i +: 8] = sd[8*(i % n) +: 8];
    end
    v = 32'h0;
    for (int j = 0; j < n; j++) v[8*j +: 8] = rdata[8*(lo + j) +: 8];
    if (!un && n < 4 && v[8*n - 1])
      for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
    res = (wr || !rd) ? 32'h0 : v;
  endfunction

  // Issue one memory op at a negedge, answer it after lat extra wait cycles, check every phase.
  task automatic mem_op(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic un, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [31:0] rdata, input int lat,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [31:0] e_res, input logic [3:0] e_be,
                        input logic e_we, input logic e_trap);
    chk1({nm, ".ready"}, ex_ready, 1'b1);
    ex_valid = 1'b1; MemRead = rd; MemWrite = wr; MemSize = sz; MemUnsigned = un;
    ALUResult = alu; StoreData = sd;
    @(negedge clk);
    ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    if (e_trap) begin
      chk1({nm, ".trap_req"}, dmem_req, 1'b0);
      chk1({nm, ".trap_wbv"}, wb_valid, 1'b0);
      chk1({nm, ".trap_stall"}, stall, 1'b0);
`ifdef MISALIGN_TRAP_EN
      chk1({nm, ".misalign"}, misalign, 1'b1);
`endif
      @(negedge clk);
`ifdef MISALIGN_TRAP_EN
      chk1({nm, ".misalign_drop"}, misalign, 1'b0);
`endif
      chk1({nm, ".trap_wbv2"}, wb_valid, 1'b0);
      return;
    end
    chk1({nm, ".req"}, dmem_req, 1'b1);
    chk1({nm, ".we"}, dmem_we, e_we);
    chk32({nm, ".addr"}, dmem_addr, e_addr);
    chk32({nm, ".be"}, {28'h0, dmem_be}, {28'h0, e_be});
    chk1({nm, ".stall"}, stall, 1'b1);
    chk1({nm, ".wbv_lo"}, wb_valid, 1'b0);
    if (e_we) chk32({nm, ".wdata"}, dmem_wdata, e_wdata);
    for (int k = 0; k < lat; k++) begin
      ex_valid = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
      ALUResult = $urandom; StoreData = $urandom;
      @(negedge clk);
      chk1({nm, ".wait_req"}, dmem_req, 1'b1);
      chk1({nm, ".wait_stall"}, stall, 1'b1);
      chk1({nm, ".wait_wbv"}, wb_valid, 1'b0);
      chk32({nm, ".wait_addr"}, dmem_addr, e_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    chk1({nm, ".wbv"}, wb_valid, 1'b1);
    chk32({nm, ".wbdata"}, wb_data, e_res);
    chk1({nm, ".req_drop"}, dmem_req, 1'b0);
    chk1({nm, ".stall_drop"}, stall, 1'b0);
  endtask

  // Back-to-back non-memory ops; results expected one cycle later in issue order.
  task automatic pass_burst(input int n, input logic use_fixed, input logic [31:0] fixed);
    logic [31:0] q[$];
    logic [31:0] v, last;
    last = 32'h0;
    for (int i = 0; i < n; i++) begin
      v = use_fixed ? fixed : $urandom;
      ex_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ALUResult = v;
      q.push_back(v);
      @(negedge clk);
      last = q.pop_front();
      chk1("pass.wbv", wb_valid, 1'b1);
      chk32("pass.data", wb_data, last);
      chk1("pass.stall", stall, 1'b0);
    end
    ex_valid = 1'b0;
    @(negedge clk);
    chk1("pass.wbv_end", wb_valid, 1'b0);
    chk32("pass.hold", wb_data, last);
  endtask

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] alu, sd, rdata;
    int          lat;
    logic [31:0] e_addr, e_wdata, e_res;
    logic [3:0]  e_be;
    logic        e_we, e_trap;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] a, wd, r;
    logic [3:0]  be;
    logic        we, tr, rd, wr, un;
    logic [1:0]  sz;
    logic [31:0] alu, sd, rdata;

    vecs[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'hAABBCCDD, 32'h0, 3,
                 32'h100, 32'hDDDDDDDD, 32'h0, 4'b1000, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h201, 32'h0, 32'h00008000, 0,
                 32'h200, 32'h0, 32'hFFFFFF80, 4'b0010, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h201, 32'h0, 32'h00008000, 0,
                 32'h200, 32'h0, 32'h00000080, 4'b0010, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 32'h80017FFF, 0,
                 32'h300, 32'h0, 32'hFFFF8001, 4'b1100, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'h80017FFF, 1,
                 32'h300, 32'h0, 32'h00008001, 4'b1100, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h401, 32'h0, 32'h12345678, 0,
                 32'h400, 32'h0, 32'h12345678, 4'b1111, 1'b0, TRAP_ON};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h006, 32'h1234ABCD, 32'h0, 1,
                 32'h004, 32'hABCDABCD, 32'h0, 4'b1100, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h008, 32'hCAFEF00D, 32'h0, 2,
                 32'h008, 32'hCAFEF00D, 32'h0, 4'b1111, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h303, 32'h0, 32'hFEDC1234, 0,
                 32'h300, 32'h0, 32'hFFFFFEDC, 4'b1100, 1'b0, TRAP_ON};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h010, 32'h00000055, 32'hFFFFFFFF, 0,
                 32'h010, 32'h55555555, 32'h0, 4'b0001, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h7F000000, 1,
                 32'h200, 32'h0, 32'h0000007F, 4'b1000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h500, 32'h0, 32'h80000001, 0,
                 32'h500, 32'h0, 32'h80000001, 4'b1111, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h001, 32'h0000BEEF, 32'h0, 0,
                 32'h000, 32'hBEEFBEEF, 32'h0, 4'b0011, 1'b1, TRAP_ON};

    reset = 1'b0; ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00;
    MemUnsigned = 1'b0; ALUResult = 32'h0; StoreData = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #2 reset = 1'b1;
    @(negedge clk);
    chk1("rst.req", dmem_req, 1'b0);
    chk1("rst.we", dmem_we, 1'b0);
    chk32("rst.addr", dmem_addr, 32'h0);
    chk32("rst.wdata", dmem_wdata, 32'h0);
    chk32("rst.be", {28'h0, dmem_be}, 32'h0);
    chk1("rst.wbv", wb_valid, 1'b0);
    chk32("rst.wbdata", wb_data, 32'h0);
    chk1("rst.ready", ex_ready, 1'b1);
    chk1("rst.stall", stall, 1'b0);
`ifdef MISALIGN_TRAP_EN
    chk1("rst.misalign", misalign, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b0;

    pass_burst(3, 1'b1, 32'h0000_1234);

    for (int i = 0; i < 13; i++)
      mem_op($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].un,
             vecs[i].alu, vecs[i].sd, vecs[i].rdata, vecs[i].lat, vecs[i].e_addr,
             vecs[i].e_wdata, vecs[i].e_res, vecs[i].e_be, vecs[i].e_we, vecs[i].e_trap);

    // Reset while a load is outstanding: request must vanish at once and never complete.
    ex_valid = 1'b1; MemRead = 1'b1; MemSize = 2'b10; ALUResult = 32'h600;
    @(negedge clk);
    ex_valid = 1'b0; MemRead = 1'b0;
    chk1("rstwait.req_before", dmem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("rstwait.req", dmem_req, 1'b0);
    chk1("rstwait.ready", ex_ready, 1'b1);
    chk1("rstwait.stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk1("rstwait.wbv1", wb_valid, 1'b0);
    chk1("rstwait.req2", dmem_req, 1'b0);
    @(negedge clk);
    chk1("rstwait.wbv2", wb_valid, 1'b0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        pass_burst($urandom_range(1, 4), 1'b0, 32'h0);
      end else begin
        rd = 1'($urandom); wr = 1'($urandom);
        if (!rd && !wr) rd = 1'b1;
        sz = 2'($urandom); un = 1'($urandom);
        alu = $urandom; sd = $urandom; rdata = $urandom;
        model(rd, wr, sz, un, alu, sd, rdata, a, wd, r, be, we, tr);
        mem_op($sformatf("rnd%0d", it), rd, wr, sz, un, alu, sd, rdata,
               $urandom_range(0, 3), a, wd, r, be, we, tr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store unit sitting directly downstream of the ALU. It takes the ALU result as the effective address, or as a pass-through result for non-memory instructions. It drives a single-port data memory over a req/ack handshake with byte enables, aligns and sign/zero-extends load data, and presents one write-back result per accepted operation. While an access is in flight it stalls the upstream stage.

Parameters:
ADDR_W, 32, width of the effective address and of dmem_addr
DATA_W, 32, data width; fixed at 32, with byte lanes 0..3

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ex_valid  input  1  EX stage presents an operation this cycle
ALUResult  input  ADDR_W  effective address (memory ops) or result (non-memory ops)
MemRead  input  1  operation is a load
MemWrite  input  1  operation is a store
MemSize  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
MemUnsigned  input  1  zero-extend loads (lbu/lhu) when 1, sign-extend when 0
StoreData  input  32  rs2 value for stores
ex_ready  output  1  unit accepts an operation this cycle
stall  output  1  upstream must hold; equals ~ex_ready
dmem_req  output  1  memory request, held until ack
dmem_we  output  1  1 = write
dmem_addr  output  ADDR_W  word-aligned address, low 2 bits always 0
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_ack  input  1  memory completed request (read data valid same cycle)
dmem_rdata  input  32  raw word read data
wb_valid  output  1  one-cycle pulse, result ready
wb_data  output  32  write-back value
misalign  output  1  present only with MISALIGN_TRAP_EN

Behaviour:
- FSM states: IDLE, WAIT. ex_ready = (state == IDLE).
- Reset (async): state is IDLE. dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_data and misalign are all 0. ex_ready is 1 and stall is 0.
- IDLE, ex_valid with MemRead=MemWrite=0: on the next cycle wb_data=ALUResult and wb_valid=1. State stays IDLE. Back-to-back issue gives one result per cycle.
- IDLE, ex_valid with MemRead or MemWrite:
  - Latch offset=ALUResult[1:0], size and unsigned flag.
  - Next cycle: dmem_req=1, dmem_addr={ALUResult[ADDR_W-1:2],2'b00}, dmem_we=MemWrite. State moves to WAIT.
  - If MemRead and MemWrite are both 1, the store wins.
- Byte enables:
  - byte: 4'b0001<<offset
  - half: 4'b0011<<{offset[1],1'b0}
  - word: 4'b1111
- Store data lanes:
  - byte: {4{StoreData[7:0]}}
  - half: {2{StoreData[15:0]}}
  - word: StoreData
- WAIT:
  - dmem_* outputs are held stable, and stall=1.
  - On dmem_ack=1, on the next cycle dmem_req=0, wb_valid=1 and state returns to IDLE.
  - Load result: shift dmem_rdata right by offset*8 (half uses {offset[1],0}*8), then extend from bit 7 or bit 15 according to MemUnsigned. Word loads pass through.
  - Store: wb_data=0.
  - ex_valid is ignored in WAIT.
- Minimum load/store latency: 2 cycles from accept to wb_valid (ack arrives in the first WAIT cycle). Each extra wait cycle adds 1.
- wb_valid is asserted for exactly one cycle per accepted operation. wb_data holds its value until the next wb_valid.
- Misaligned access without the feature: the offending low address bits are ignored.
  - half with offset[0]=1 uses lanes {offset[1],0}.
  - word with any nonzero offset is treated as aligned.
- Reset asserted during WAIT: dmem_req drops immediately and the pending access is abandoned. No wb_valid is produced for it.

Optional Feature:
Macro: MISALIGN_TRAP_EN.
- Defined:
  - misalign port exists.
  - An accepted half access with offset[0]=1, or word access with offset!=0, issues no dmem_req.
  - Next cycle: misalign=1 for one cycle, wb_valid=0, state stays IDLE.
- Not defined: the port is absent and the truncation behaviour above applies.

Test Plan:
- Reset mid-WAIT: issue lw, assert reset before ack -> dmem_req=0 immediately, ex_ready=1, no wb_valid after release.
- Non-memory pass-through: ALUResult=0x0000_1234, 3 consecutive cycles -> wb_valid high 3 cycles, wb_data=0x1234 each, one cycle late, stall=0 throughout.
- Byte store: sb, ALUResult=0x103, StoreData=0xAABBCCDD -> dmem_addr=0x100, dmem_be=4'b1000, dmem_wdata=0xDDDDDDDD, dmem_we=1. Ack after 3 wait cycles -> stall held 4 cycles, then wb_valid.
- Sign-extended load: lb, ALUResult=0x201, dmem_rdata=0x0000_8000 acked first WAIT cycle -> wb_data=0xFFFF_FF80, 2 cycles after accept. Repeat as lbu -> wb_data=0x0000_0080.
- Halfword load: lh, ALUResult=0x302, rdata=0x8001_7FFF -> wb_data=0xFFFF_8001; lhu -> 0x0000_8001.
- Misaligned lw at 0x401: without macro -> dmem_addr=0x400, dmem_be=4'b1111. With MISALIGN_TRAP_EN -> no dmem_req, misalign=1 one cycle, no wb_valid.
